p4_router_queue_state: RTL and testbench
========================================

Name: p4_router_queue_state

Overview:
- Per-queue packet-descriptor store and dequeue-word tracker for the P4 router egress path.
- Downstream neighbour of the scheduler. It drives the scheduler's `queue_empty` vector and consumes its one-word dequeue requests `{egr_port, queue}`.
- Returns a dequeue notification per word, with `tlast` on a packet's final word. The scheduler uses `tlast` to release its per-port packet lock.
- Descriptors are written by the enqueue stage as `{qid, len_words}`.

Parameters:
- NUM_EGR_PORTS, 4, number of egress ports.
- NUM_QUEUES_PER_EGR_PORT, 8, queues per port; must be a power of 2 and equal the package constant.
- DESC_DEPTH, 16, descriptor slots per queue; must be a power of 2.
- MTU_BYTES, 2000, largest packet.
- DATA_BYTES, 64, bytes per data word.
- DQ_LATENCY, 3, request-to-notification latency in cycles; must match the scheduler; must be at least 1.
- Derived: NUM_QUEUES = NUM_EGR_PORTS*NUM_QUEUES_PER_EGR_PORT.
- Derived: QID_W = clog2(NUM_EGR_PORTS)+clog2(NUM_QUEUES_PER_EGR_PORT).
- Derived: MAX_WORDS = ceil(MTU_BYTES/DATA_BYTES).
- Derived: LEN_W = clog2(MAX_WORDS+1).

Ports:
- clk  in  1  sole clock.
- srst  in  1  synchronous reset, active-high.
- enq_tvalid  in  1  descriptor valid.
- enq_tready  out  1  tied 1; the block never back-pressures.
- enq_tdata  in  QID_W+LEN_W  {qid, len_words}.
- queue_empty  out  NUM_QUEUES  bit q = queue q holds no descriptor.
- queue_full  out  NUM_QUEUES  bit q = queue q holds DESC_DEPTH descriptors.
- deq_req_tvalid  in  1  one-word dequeue request.
- deq_req_tdata  in  QID_W  {egr_port, queue}.
- deq_ntf_tvalid  out  1  word dequeued.
- deq_ntf_tlast  out  1  final word of the packet.
- deq_ntf_tdata  out  LEN_W  word index within the packet, 0-based.
- deq_ntf_tuser  out  QID_W  queue id of the dequeued word.
- drop_err  out  1  one-cycle pulse when an enqueue is rejected.
- underflow_err  out  1  one-cycle pulse when a dequeue request is rejected.

Behaviour:
- **Reset:** srst is sampled on the clk edge. It clears all per-queue read/write pointers, counts, word counters and the notification pipeline.
  - After reset: queue_empty = all 1s; queue_full = all 0s; deq_ntf_tvalid = 0, tlast = 0, tdata = 0, tuser = 0; drop_err = 0; underflow_err = 0.
  - Reset mid-packet discards everything. No notification emerges from requests accepted before reset.
- **Storage:** per-queue circular FIFO of len_words, DESC_DEPTH deep. Each queue has rd_ptr, wr_ptr and count (clog2(DESC_DEPTH)+1 bits). Each queue has a head word counter head_idx (LEN_W bits).
- **Enqueue:** accepted when enq_tvalid is high.
  - If queue_full[qid], or len_words == 0, or len_words > MAX_WORDS, or qid >= NUM_QUEUES: drop the descriptor and pulse drop_err the next cycle.
  - Otherwise write the slot at wr_ptr, increment wr_ptr (wraps modulo DESC_DEPTH) and increment count.
- **Dequeue request:** with deq_req_tvalid high and the current (registered) queue_empty[q] == 0:
  - Emit word index head_idx.
  - last = (head_idx == head_len-1).
  - If last: head_idx <= 0, rd_ptr++ (wraps), count--. Otherwise head_idx++.
  - The request is consumed in the cycle it is presented; no ready signal exists.
- **Rejected request:** if queue q is empty, or q >= NUM_QUEUES, drop the request and pulse underflow_err the next cycle. No notification is produced and state is unchanged.
  - The scheduler may over-request by up to DQ_LATENCY words. These are benign rejects.
- **Notification pipeline:** DQ_LATENCY-stage shift of {valid, last, idx, qid}. A request accepted at cycle N gives deq_ntf_tvalid at cycle N+DQ_LATENCY. Order follows request order; there are no bubbles beyond the request gaps.
- **Flag timing:** queue_empty and queue_full are registered from count and update the cycle after the commit. A pop at cycle N clears the queue at N+1.
- **Simultaneous enqueue and last-word pop, same queue:** both commit; count stays the same. If count was DESC_DEPTH, the enqueue is judged against the pre-pop full flag and is dropped.
- **Enqueue and request to an empty queue, same cycle:** the request sees empty, so it is rejected with underflow_err; the enqueue commits.
- **len_words = 1:** each request is a last word. The descriptor pops every accepted request.
- **Width rules:** qid maps to {port, queue} with the queue in the LSBs, matching the scheduler's concatenation. Counters never exceed their bounds because of the reject rules above.

Test Plan:
1. Reset, then enqueue {q=5, len=3} -> queue_empty[5] falls one cycle later; three requests to q5 at cycles 10, 11, 12 -> notifications at 13, 14, 15 with tdata 0, 1, 2, tlast only at 15, tuser = 5; queue_empty[5] rises at cycle 13.
2. Enqueue 16 descriptors (len=1) into q0, then a 17th -> queue_full[0] = 1 and drop_err pulses once; 16 requests drain it and a 17th request gives underflow_err with no notification.
3. q2 full (count=16), same-cycle enqueue and last-word pop -> enqueue dropped (drop_err), count = 15.
4. Same cycle: enqueue to empty q7 and request q7 -> underflow_err; the next-cycle request succeeds with tdata = 0.
5. Descriptors with len=0 and len=MAX_WORDS+1 -> both dropped with drop_err; queue_empty unchanged.
6. Three of five words of a q1 packet dequeued, srst asserted for 1 cycle with notifications in flight -> no deq_ntf_tvalid after reset; all flags return to their reset values.

Source files
------------

// File: rtl/p4_router_queue_state_if.sv
// Enqueue / dequeue-request / notification bundle for the egress queue-state block.
// "slave" is the queue-state side; "master" is the enqueue stage plus scheduler.
interface p4_router_queue_state_if #(
    parameter int NUM_EGR_PORTS           = 4,
    parameter int NUM_QUEUES_PER_EGR_PORT = 8,
    parameter int MTU_BYTES               = 2000,
    parameter int DATA_BYTES              = 64
);
    localparam int NUM_QUEUES = NUM_EGR_PORTS * NUM_QUEUES_PER_EGR_PORT;
    localparam int QID_W      = $clog2(NUM_EGR_PORTS) + $clog2(NUM_QUEUES_PER_EGR_PORT);
    localparam int MAX_WORDS  = (MTU_BYTES + DATA_BYTES - 1) / DATA_BYTES;
    localparam int LEN_W      = $clog2(MAX_WORDS + 1);

    logic                   enq_tvalid;
    logic                   enq_tready;
    logic [QID_W+LEN_W-1:0] enq_tdata;
    logic [NUM_QUEUES-1:0]  queue_empty;
    logic [NUM_QUEUES-1:0]  queue_full;
    logic                   deq_req_tvalid;
    logic [QID_W-1:0]       deq_req_tdata;
    logic                   deq_ntf_tvalid;
    logic                   deq_ntf_tlast;
    logic [LEN_W-1:0]       deq_ntf_tdata;
    logic [QID_W-1:0]       deq_ntf_tuser;
    logic                   drop_err;
    logic                   underflow_err;

    modport master (
        output enq_tvalid, enq_tdata, deq_req_tvalid, deq_req_tdata,
        input  enq_tready, queue_empty, queue_full,
        input  deq_ntf_tvalid, deq_ntf_tlast, deq_ntf_tdata, deq_ntf_tuser,
        input  drop_err, underflow_err
    );

    modport slave (
        input  enq_tvalid, enq_tdata, deq_req_tvalid, deq_req_tdata,
        output enq_tready, queue_empty, queue_full,
        output deq_ntf_tvalid, deq_ntf_tlast, deq_ntf_tdata, deq_ntf_tuser,
        output drop_err, underflow_err
    );
endinterface

// File: rtl/p4_router_queue_state.sv
// Per-queue descriptor FIFOs with head word tracking, feeding a fixed-latency
// dequeue notification pipe back to the scheduler.
module p4_rqs_queue #(
    parameter int DESC_DEPTH = 16,
    parameter int LEN_W      = 6
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [LEN_W-1:0] push_len,
    input  logic             pop,
    output logic             empty,
    output logic             full,
    output logic [LEN_W-1:0] head_idx,
    output logic             head_last
);
    localparam int PTR_W = $clog2(DESC_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [LEN_W-1:0] mem [DESC_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count, count_nxt;

    assign head_last = (head_idx == mem[rd_ptr] - LEN_W'(1));

    always_comb begin
        count_nxt = count;
        case ({push, pop && head_last})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_len;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            head_idx <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                if (head_last) begin
                    head_idx <= '0;
                    rd_ptr   <= rd_ptr + PTR_W'(1);
                end else begin
                    head_idx <= head_idx + LEN_W'(1);
                end
            end
            count <= count_nxt;
            // flags lag the commit by one cycle; callers gate on the registered view
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CNT_W'(DESC_DEPTH));
        end
    end
endmodule

module p4_router_queue_state #(
    parameter int NUM_EGR_PORTS           = 4,
    parameter int NUM_QUEUES_PER_EGR_PORT = 8,
    parameter int DESC_DEPTH              = 16,
    parameter int MTU_BYTES               = 2000,
    parameter int DATA_BYTES              = 64,
    parameter int DQ_LATENCY              = 3
) (
    input logic                    clk,
    input logic                    srst,
    p4_router_queue_state_if.slave qs
);
    localparam int NUM_QUEUES = NUM_EGR_PORTS * NUM_QUEUES_PER_EGR_PORT;
    localparam int QID_W      = $clog2(NUM_EGR_PORTS) + $clog2(NUM_QUEUES_PER_EGR_PORT);
    localparam int MAX_WORDS  = (MTU_BYTES + DATA_BYTES - 1) / DATA_BYTES;
    localparam int LEN_W      = $clog2(MAX_WORDS + 1);
    localparam logic [QID_W:0]   NQ_LIM  = (QID_W+1)'(NUM_QUEUES);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

    typedef struct packed {
        logic             last;
        logic [LEN_W-1:0] idx;
        logic [QID_W-1:0] qid;
    } ntf_t;

    logic [QID_W-1:0] enq_qid, req_qid;
    logic [LEN_W-1:0] enq_len;
    logic             enq_ok, req_ok;
    logic             drop_q, under_q;

    logic [NUM_QUEUES-1:0]            push, pop, q_empty, q_full, q_last;
    logic [NUM_QUEUES-1:0][LEN_W-1:0] q_head;

    logic [DQ_LATENCY:1] vld_pipe;
    ntf_t                ntf_pipe [DQ_LATENCY:1];
    ntf_t                ntf_in;

    assign enq_qid = qs.enq_tdata[QID_W+LEN_W-1:LEN_W];
    assign enq_len = qs.enq_tdata[LEN_W-1:0];
    assign req_qid = qs.deq_req_tdata;

    // both sides judge against the registered flags, so same-cycle push/pop never overflow
    assign enq_ok = qs.enq_tvalid && ({1'b0, enq_qid} < NQ_LIM) && (enq_len != '0)
                    && (enq_len <= MAX_LEN) && !q_full[enq_qid];
    assign req_ok = qs.deq_req_tvalid && ({1'b0, req_qid} < NQ_LIM) && !q_empty[req_qid];

    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_q
        assign push[q] = enq_ok && (enq_qid == QID_W'(q));
        assign pop[q]  = req_ok && (req_qid == QID_W'(q));

        p4_rqs_queue #(.DESC_DEPTH(DESC_DEPTH), .LEN_W(LEN_W)) u_queue (
            .clk       (clk),
            .srst      (srst),
            .push      (push[q]),
            .push_len  (enq_len),
            .pop       (pop[q]),
            .empty     (q_empty[q]),
            .full      (q_full[q]),
            .head_idx  (q_head[q]),
            .head_last (q_last[q])
        );
    end

    assign ntf_in = '{last: q_last[req_qid], idx: q_head[req_qid], qid: req_qid};

    always_ff @(posedge clk) begin
        if (srst) begin
            vld_pipe <= '0;
            for (int s = 1; s <= DQ_LATENCY; s++) ntf_pipe[s] <= '0;
            drop_q   <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            vld_pipe[1] <= req_ok;
            ntf_pipe[1] <= req_ok ? ntf_in : '0;
            for (int s = 2; s <= DQ_LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                ntf_pipe[s] <= ntf_pipe[s-1];
            end
            drop_q  <= qs.enq_tvalid && !enq_ok;
            under_q <= qs.deq_req_tvalid && !req_ok;
        end
    end

    assign qs.enq_tready     = 1'b1;
    assign qs.queue_empty    = q_empty;
    assign qs.queue_full     = q_full;
    assign qs.deq_ntf_tvalid = vld_pipe[DQ_LATENCY];
    assign qs.deq_ntf_tlast  = ntf_pipe[DQ_LATENCY].last;
    assign qs.deq_ntf_tdata  = ntf_pipe[DQ_LATENCY].idx;
    assign qs.deq_ntf_tuser  = ntf_pipe[DQ_LATENCY].qid;
    assign qs.drop_err       = drop_q;
    assign qs.underflow_err  = under_q;
endmodule

// File: tb/tb_p4_router_queue_state.sv
// Directed bench for p4_router_queue_state: fixed cycle-by-cycle vectors with
// hand-derived expectations (32 queues, 16-deep, MAX_WORDS 32, latency 3).
module tb_p4_router_queue_state;
    localparam int QID_W = 5;
    localparam int LEN_W = 6;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    p4_router_queue_state_if #(
        .NUM_EGR_PORTS(4), .NUM_QUEUES_PER_EGR_PORT(8), .MTU_BYTES(2000), .DATA_BYTES(64)
    ) bus ();

    p4_router_queue_state #(
        .NUM_EGR_PORTS(4), .NUM_QUEUES_PER_EGR_PORT(8), .DESC_DEPTH(16),
        .MTU_BYTES(2000), .DATA_BYTES(64), .DQ_LATENCY(3)
    ) dut (
        .clk  (clk),
        .srst (srst),
        .qs   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int ntf_cnt = 0;
    int last_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one clock; outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.deq_ntf_tvalid === 1'b1) begin
            ntf_cnt++;
            if (bus.deq_ntf_tlast === 1'b1) last_cnt++;
        end
    endtask

    task automatic idle();
        bus.enq_tvalid     = 1'b0;
        bus.enq_tdata      = '0;
        bus.deq_req_tvalid = 1'b0;
        bus.deq_req_tdata  = '0;
    endtask

    task automatic set_enq(input int q, input int len);
        bus.enq_tvalid = 1'b1;
        bus.enq_tdata  = {QID_W'(q), LEN_W'(len)};
    endtask

    task automatic set_req(input int q);
        bus.deq_req_tvalid = 1'b1;
        bus.deq_req_tdata  = QID_W'(q);
    endtask

    initial begin
        srst = 1'b1;
        idle();
        tick();
        tick();
        srst = 1'b0;
        chk("rst_empty", bus.queue_empty, 32'hffff_ffff);
        chk("rst_full", bus.queue_full, 32'h0);
        chk("rst_vld", 32'(bus.deq_ntf_tvalid), 32'd0);
        chk("rst_last", 32'(bus.deq_ntf_tlast), 32'd0);
        chk("rst_tdata", 32'(bus.deq_ntf_tdata), 32'd0);
        chk("rst_tuser", 32'(bus.deq_ntf_tuser), 32'd0);
        chk("rst_drop", 32'(bus.drop_err), 32'd0);
        chk("rst_under", 32'(bus.underflow_err), 32'd0);
        chk("enq_tready", 32'(bus.enq_tready), 32'd1);

        // 1: three-word packet on q5
        set_enq(5, 3);
        tick();
        idle();
        chk("t1_empty5_fall", 32'(bus.queue_empty[5]), 32'd0);
        set_req(5);
        tick();
        chk("t1_no_early_ntf", 32'(bus.deq_ntf_tvalid), 32'd0);
        tick();
        tick();
        idle();
        chk("t1_w0_vld", 32'(bus.deq_ntf_tvalid), 32'd1);
        chk("t1_w0_idx", 32'(bus.deq_ntf_tdata), 32'd0);
        chk("t1_w0_last", 32'(bus.deq_ntf_tlast), 32'd0);
        chk("t1_w0_tuser", 32'(bus.deq_ntf_tuser), 32'd5);
        chk("t1_empty5_rise", 32'(bus.queue_empty[5]), 32'd1);
        tick();
        chk("t1_w1_idx", 32'(bus.deq_ntf_tdata), 32'd1);
        chk("t1_w1_last", 32'(bus.deq_ntf_tlast), 32'd0);
        tick();
        chk("t1_w2_idx", 32'(bus.deq_ntf_tdata), 32'd2);
        chk("t1_w2_last", 32'(bus.deq_ntf_tlast), 32'd1);
        chk("t1_w2_tuser", 32'(bus.deq_ntf_tuser), 32'd5);
        tick();
        chk("t1_done_vld", 32'(bus.deq_ntf_tvalid), 32'd0);

        // 2: fill q0, overflow once, drain, underflow once
        for (int i = 0; i < 16; i++) begin
            set_enq(0, 1);
            tick();
        end
        chk("t2_no_drop", 32'(bus.drop_err), 32'd0);
        chk("t2_full0", 32'(bus.queue_full[0]), 32'd1);
        tick();
        idle();
        chk("t2_drop", 32'(bus.drop_err), 32'd1);
        chk("t2_still_full", 32'(bus.queue_full[0]), 32'd1);
        tick();
        chk("t2_drop_pulse", 32'(bus.drop_err), 32'd0);
        ntf_cnt = 0;
        last_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            set_req(0);
            tick();
        end
        chk("t2_empty0", 32'(bus.queue_empty[0]), 32'd1);
        chk("t2_full0_clr", 32'(bus.queue_full[0]), 32'd0);
        tick();
        idle();
        chk("t2_under", 32'(bus.underflow_err), 32'd1);
        tick();
        tick();
        tick();
        chk("t2_ntf_cnt", 32'(ntf_cnt), 32'd16);
        chk("t2_last_cnt", 32'(last_cnt), 32'd16);

        // 3: full q2, same-cycle enqueue and last-word pop
        for (int i = 0; i < 16; i++) begin
            set_enq(2, 1);
            tick();
        end
        idle();
        chk("t3_full2", 32'(bus.queue_full[2]), 32'd1);
        set_enq(2, 1);
        set_req(2);
        tick();
        idle();
        ntf_cnt = 0;
        chk("t3_drop", 32'(bus.drop_err), 32'd1);
        chk("t3_full2_clr", 32'(bus.queue_full[2]), 32'd0);
        chk("t3_empty2", 32'(bus.queue_empty[2]), 32'd0);
        for (int i = 0; i < 15; i++) begin
            set_req(2);
            tick();
        end
        chk("t3_under_early", 32'(bus.underflow_err), 32'd0);
        tick();
        idle();
        chk("t3_under", 32'(bus.underflow_err), 32'd1);
        tick();
        tick();
        tick();
        chk("t3_ntf_cnt", 32'(ntf_cnt), 32'd16);

        // 4: enqueue and request to empty q7 in the same cycle
        set_enq(7, 2);
        set_req(7);
        tick();
        idle();
        chk("t4_under", 32'(bus.underflow_err), 32'd1);
        chk("t4_empty7", 32'(bus.queue_empty[7]), 32'd0);
        set_req(7);
        tick();
        idle();
        chk("t4_under_clr", 32'(bus.underflow_err), 32'd0);
        tick();
        tick();
        chk("t4_vld", 32'(bus.deq_ntf_tvalid), 32'd1);
        chk("t4_idx", 32'(bus.deq_ntf_tdata), 32'd0);
        chk("t4_last", 32'(bus.deq_ntf_tlast), 32'd0);
        chk("t4_tuser", 32'(bus.deq_ntf_tuser), 32'd7);

        // 5: length bounds on q3
        set_enq(3, 0);
        tick();
        idle();
        chk("t5_len0_drop", 32'(bus.drop_err), 32'd1);
        chk("t5_len0_empty", 32'(bus.queue_empty[3]), 32'd1);
        set_enq(3, 33);
        tick();
        idle();
        chk("t5_len33_drop", 32'(bus.drop_err), 32'd1);
        chk("t5_len33_empty", 32'(bus.queue_empty[3]), 32'd1);
        set_enq(3, 32);
        tick();
        idle();
        chk("t5_len32_ok", 32'(bus.drop_err), 32'd0);
        chk("t5_len32_empty", 32'(bus.queue_empty[3]), 32'd0);

        // 6: reset with notifications in flight
        set_enq(1, 5);
        tick();
        set_req(1);
        tick();
        tick();
        tick();
        idle();
        chk("t6_inflight", 32'(bus.deq_ntf_tvalid), 32'd1);
        srst = 1'b1;
        ntf_cnt = 0;
        tick();
        srst = 1'b0;
        chk("t6_empty", bus.queue_empty, 32'hffff_ffff);
        chk("t6_full", bus.queue_full, 32'h0);
        chk("t6_drop", 32'(bus.drop_err), 32'd0);
        chk("t6_under", 32'(bus.underflow_err), 32'd0);
        chk("t6_tdata", 32'(bus.deq_ntf_tdata), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("t6_no_ntf", 32'(ntf_cnt), 32'd0);
        set_enq(1, 2);
        tick();
        idle();
        set_req(1);
        tick();
        idle();
        tick();
        tick();
        chk("t6_post_vld", 32'(bus.deq_ntf_tvalid), 32'd1);
        chk("t6_post_idx", 32'(bus.deq_ntf_tdata), 32'd0);
        chk("t6_post_tuser", 32'(bus.deq_ntf_tuser), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
